// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: active-low segment codes {g,f,e,d,c,b,a} for hex digits 0..F,
// the all-dark segment and anode patterns, and the digit count.
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment code decoder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
// Ports: i_nib - 4-bit hex digit; o_seg - {g,f,e,d,c,b,a}, 0 = segment lit.
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver with per-frame input latch and
// inter-digit blanking gap. Latency: an/seg/dp are registered, 1 clk behind
// the internal scan state. Backpressure: none; inputs are sampled once per frame.
// Ports: clk, rst (sync, active high); value[15:0] hex digits ([3:0] = an[0]),
// dp_in[3:0] decimal points (1 = lit), blank_in[3:0] (1 = dark);
// an[3:0], seg[6:0] {g..a}, dp all active low; frame_start = latch pulse.
module seven_seg_scan
  import disp_pkg::*;
#(
  parameter int PRESCALE_W = 15,
  parameter int GAP        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam logic [PRESCALE_W-1:0] GAP_CNT = PRESCALE_W'(GAP);

  logic [PRESCALE_W-1:0] r_cnt;
  logic [1:0]            r_idx;
  logic [15:0]           r_value_q;
  logic [3:0]            r_dp_q;
  logic [3:0]            r_blank_q;
  logic [3:0]            r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frame_start;

  logic                  w_tick;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;
  logic [3:0]            w_an_sel;
  logic                  w_dark;

  assign w_tick   = (r_cnt == '1);
  assign w_nib    = 4'(r_value_q >> {r_idx, 2'b00});
  assign w_an_sel = ~(4'b0001 << r_idx);
  // Dark during the post-switch gap (anti-ghosting) or when the digit is masked.
  assign w_dark   = (r_cnt < GAP_CNT) | r_blank_q[r_idx];

  hex_to_seg u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // Prescaler and digit index; the index only moves on the wrap tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  // Frame latch: inputs are captured only when leaving the last digit, so a
  // whole frame always shows one consistent snapshot. blank_q resets to all
  // ones to keep the display dark until the first real frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value_q     <= 16'h0000;
      r_dp_q        <= 4'h0;
      r_blank_q     <= 4'hF;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_tick && (r_idx == 2'd3)) begin
        r_value_q     <= value;
        r_dp_q        <= dp_in;
        r_blank_q     <= blank_in;
        r_frame_start <= 1'b1;
      end
    end
  end

  // Single output register stage so an, seg and dp switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else if (w_dark) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_sel;
      r_seg <= w_seg;
      r_dp  <= ~r_dp_q[r_idx];
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

  localparam int PW    = 3;
  localparam int GAP   = 2;
  localparam int SLOT  = 1 << PW;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seven_seg_scan #(.PRESCALE_W(PW), .GAP(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // Reference decode table, straight from the digit shapes.
  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: time since reset release determines slot position and
  // digit; the displayed snapshot is what was presented at each frame end.
  int          m_n = 0;
  logic [15:0] m_val = 16'h0000;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  m_bl = 4'hF;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_fs = 1'b0;

  task automatic step();
    logic        r;
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  b;
    int          pos;
    int          dig;
    r = rst; v = value; d = dp_in; b = blank_in;
    @(posedge clk);
    #1;
    if (r) begin
      m_n = 0; m_val = 16'h0000; m_dp = 4'h0; m_bl = 4'hF;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      pos = m_n % SLOT;
      dig = (m_n / SLOT) % 4;
      if (pos < GAP || m_bl[dig]) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(4'b0001 << dig);
        e_seg = seg_tbl[m_val[dig*4 +: 4]];
        e_dp  = ~m_dp[dig];
      end
      e_fs = ((m_n % FRAME) == FRAME - 1);
      if (e_fs) begin
        m_val = v; m_dp = d; m_bl = b;
      end
      m_n++;
    end
  endtask

  // Advance until a frame_start is observed, bounded by one frame plus slack.
  task automatic wait_fs(input string tag);
    int k;
    for (k = 0; k < FRAME + 2; k++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        errors++;
        $display("FAIL %s_model an=%b seg=%b dp=%b fs=%b want an=%b seg=%b dp=%b fs=%b",
                 tag, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
      end
      if (frame_start === 1'b1) break;
    end
    checks++;
    if (k >= FRAME + 2) begin
      errors++;
      $display("FAIL %s_fs_timeout waited %0d cycles, want frame_start within %0d", tag, k, FRAME + 2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    value = 16'hBEEF; dp_in = 4'hF; blank_in = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold an=%b seg=%b dp=%b fs=%b want 1111 1111111 1 0", an, seg, dp, frame_start);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        errors++;
        $display("FAIL reset_dark cyc=%0d an=%b seg=%b dp=%b want 1111 1111111 1", i, an, seg, dp);
      end
      checks++;
      if (frame_start !== (i == FRAME - 1)) begin
        errors++;
        $display("FAIL reset_first_fs cyc=%0d fs=%b want %b", i, frame_start, (i == FRAME - 1));
      end
    end
  endtask

  task automatic test_decode_scan();
    logic [3:0] order [4];
    logic [6:0] seen_seg [4];
    int         lit [4];
    int         nord;
    int         dark;
    logic [3:0] want_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] want_seg [4] = '{7'b0001110, 7'b0000000, 7'b0001000, 7'b1111001};
    value = 16'h1A8F; dp_in = 4'h0; blank_in = 4'h0;
    wait_fs("decode");
    nord = 0; dark = 0;
    for (int d = 0; d < 4; d++) begin lit[d] = 0; seen_seg[d] = 7'h7F; order[d] = 4'hF; end
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        errors++;
        $display("FAIL decode_model an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, e_an, e_seg, e_dp);
      end
      if (an === 4'hF) dark++;
      for (int d = 0; d < 4; d++) begin
        if (an === want_an[d]) begin
          if (lit[d] == 0 && nord < 4) begin order[nord] = an; nord++; seen_seg[d] = seg; end
          lit[d]++;
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (order[d] !== want_an[d]) begin
        errors++;
        $display("FAIL decode_order pos=%0d an=%b want %b", d, order[d], want_an[d]);
      end
      checks++;
      if (seen_seg[d] !== want_seg[d]) begin
        errors++;
        $display("FAIL decode_seg digit=%0d seg=%b want %b", d, seen_seg[d], want_seg[d]);
      end
      checks++;
      if (lit[d] != SLOT - GAP) begin
        errors++;
        $display("FAIL decode_lit digit=%0d cycles=%0d want %0d", d, lit[d], SLOT - GAP);
      end
    end
    checks++;
    if (dark != 4 * GAP) begin
      errors++;
      $display("FAIL decode_dark cycles=%0d want %0d", dark, 4 * GAP);
    end
  endtask

  task automatic test_no_tearing();
    logic [15:0] shown;
    value = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
    wait_fs("tear");
    for (int f = 0; f < 2; f++) begin
      shown = (f == 0) ? 16'h1234 : 16'h5678;
      for (int i = 0; i < FRAME; i++) begin
        if (f == 0 && i == 12) value = 16'h5678;
        step();
        checks++;
        if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
          errors++;
          $display("FAIL tear_model an=%b seg=%b want an=%b seg=%b", an, seg, e_an, e_seg);
        end
        for (int d = 0; d < 4; d++) begin
          if (an === ~(4'b0001 << d)) begin
            checks++;
            if (seg !== seg_tbl[shown[d*4 +: 4]]) begin
              errors++;
              $display("FAIL tear_digit frame=%0d digit=%0d seg=%b want %b", f, d, seg, seg_tbl[shown[d*4 +: 4]]);
            end
          end
        end
      end
      checks++;
      if (frame_start !== 1'b1) begin
        errors++;
        $display("FAIL tear_boundary frame=%0d fs=%b want 1", f, frame_start);
      end
    end
  endtask

  task automatic test_masks();
    int dp_lit;
    value = 16'($urandom); dp_in = 4'b0001; blank_in = 4'b0100;
    wait_fs("mask");
    dp_lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        errors++;
        $display("FAIL mask_model an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, e_an, e_seg, e_dp);
      end
      checks++;
      if (an === 4'b1011) begin
        errors++;
        $display("FAIL mask_blank cyc=%0d an=%b want never 1011", i, an);
      end
      checks++;
      if (dp !== (an === 4'b1110 ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL mask_dp cyc=%0d an=%b dp=%b want %b", i, an, dp, (an === 4'b1110 ? 1'b0 : 1'b1));
      end
      if (dp === 1'b0) dp_lit++;
    end
    checks++;
    if (dp_lit != SLOT - GAP) begin
      errors++;
      $display("FAIL mask_dp_count cycles=%0d want %0d", dp_lit, SLOT - GAP);
    end
  endtask

  task automatic test_mid_reset();
    value = 16'hC0DE; dp_in = 4'hF; blank_in = 4'h0;
    wait_fs("midrst");
    // Move into the third digit's slot (lit part) before pulsing reset.
    for (int i = 0; i < 2 * SLOT + GAP + 2; i++) step();
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL midrst_pre an=%b want 1011", an);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midrst_edge an=%b seg=%b dp=%b fs=%b want 1111 1111111 1 0", an, seg, dp, frame_start);
    end
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        errors++;
        $display("FAIL midrst_dark cyc=%0d an=%b seg=%b dp=%b want dark", i, an, seg, dp);
      end
      checks++;
      if (frame_start !== (i == FRAME - 1)) begin
        errors++;
        $display("FAIL midrst_fs cyc=%0d fs=%b want %b", i, frame_start, (i == FRAME - 1));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 5) == 0) value = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 9) == 0) blank_in = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      rst = ($urandom_range(0, 99) == 0);
      step();
      checks++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        errors++;
        $display("FAIL random_model cyc=%0d an=%b seg=%b dp=%b fs=%b want an=%b seg=%b dp=%b fs=%b",
                 i, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode_scan();
    test_no_tearing();
    test_masks();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Four-digit, time-multiplexed seven-segment display driver that sits directly downstream of the clock divider stage. Instead of consuming a divided clock, it runs entirely on the board clock. It derives its own digit-scan enable from an internal prescaler of the same width as the divider counter. Each frame it latches a 16-bit hex value plus decimal-point and blank masks, then drives active-low anode and segment lines with a short inter-digit blanking gap to suppress ghosting.

## Interface
- PRESCALE_W, 15, prescaler width; scan tick period is 2^PRESCALE_W clk cycles per digit.
- GAP, 4, number of cycles all anodes are off after each digit change; legal range 0 to 2^PRESCALE_W − 1.
- clk  input  1  board clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- value  input  16  four hex digits; [3:0] goes to the rightmost digit (an[0]).
- dp_in  input  4  decimal-point enables, 1 = lit, bit i belongs to digit i.
- blank_in  input  4  digit blank mask, 1 = digit dark.
- an  output  4  anode selects, active low, one-hot-low or all high.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.
- frame_start  output  1  one-cycle pulse when a new frame's inputs are latched.

## Operation
- **Prescaler `cnt`:** PRESCALE_W bits, increments every cycle and wraps.
	- `tick` = (cnt == all ones), a combinational one-cycle pulse.
- **Digit index `idx`:** 2 bits, advances on `tick` in the order 0→1→2→3→0.
- **Frame latch:** on `tick` with idx==3, load value, dp_in and blank_in into value_q, dp_q and blank_q.
	- frame_start is registered high in that same edge, so it is high during the first cycle of idx 0.
	- Inputs may change at any time; the displayed data changes only at frame boundaries, so no tearing.
- **Output function:** evaluated from the current cnt, idx and latched registers, then registered.
	- If cnt < GAP or blank_q[idx]==1: an=4'b1111, seg=7'b1111111, dp=1.
	- Otherwise: an = ~(4'b0001 << idx), seg = hex decode of value_q[4·idx+3 : 4·idx], dp = ~dp_q[idx].
- **Hex decode (active low):**
	- 0=1000000, 1=1111001, 2=0100100, 3=0110000
	- 4=0011001, 5=0010010, 6=0000010, 7=1111000
	- 8=0000000, 9=0010000, A=0001000, b=0000011
	- C=1000110, d=0100001, E=0000110, F=0001110
- **Reset state:**
	- Internal: cnt=0, idx=0, value_q=0, dp_q=0, blank_q=4'hF.
	- Outputs: an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
	- The display stays dark until the first frame latch, 4·2^PRESCALE_W cycles after reset release.
- **Mid-operation reset:** rst in any cycle returns every register to its reset value at that edge, with no partial-frame residue.
	- rst takes priority over tick.
- **GAP=0:** there is no blanking gap, and an changes directly from one digit to the next.

## Timing
- Output latency is 1 clk from internal state. an, seg and dp all come from one register stage, so they change on the same edge.
- Each digit's lit window per scan slot is 2^PRESCALE_W − GAP cycles, provided the digit is not blanked.
- Frame period is 4·2^PRESCALE_W cycles. With the defaults that is 131072 cycles, about 763 Hz at 100 MHz.
- frame_start pulses exactly once per frame, at intervals of 4·2^PRESCALE_W cycles.
- **Sequence around a tick:**
	- At the tick edge, cnt wraps to 0 and idx increments.
	- The next edge registers an=1111, which opens the gap.
	- an shows the new digit starting GAP+1 edges after the tick edge.

## Structure
- **Shared package `disp_pkg`:**
	- Segment-code constants SEG_0..SEG_F and SEG_OFF=7'b1111111.
	- AN_OFF=4'b1111.
	- Localparam NUM_DIGITS=4.
- **One sub-module, `hex_to_seg`:** purely combinational, 4-bit nibble in, 7-bit active-low code out. It is reusable by other display blocks.
- **Top-level contents:**
	- Prescaler, idx counter, frame latch and the output register stage.
	- No FSM beyond the idx counter; the sequencing comes from the counter.

## Test plan
All scenarios use PRESCALE_W=3 and GAP=2 (8-cycle slots).
- **Reset behaviour:** hold rst for 3 cycles, then release.
	- Outputs: an=1111, seg=1111111, dp=1 throughout reset and for the following 32 cycles.
	- frame_start first pulses 32 cycles after release.
- **Decode and scan:** value=16'h1A8F, dp_in=0, blank_in=0.
	- In the next frame: an=1110 with seg=0001110, then an=1101 with seg=0000000, then an=1011 with seg=0001000, then an=0111 with seg=1111001.
	- Each digit is lit for 6 cycles, with 2 dark cycles between digits.
- **No tearing:** change value from 16'h1234 to 16'h5678 in the middle of a frame.
	- All four digits of the current frame still show 1234; 5678 appears only after the next frame_start.
- **Masks:** blank_in=4'b0100, dp_in=4'b0001.
	- Digit 2 stays dark: an never equals 1011 for a full frame.
	- dp=0 only while an=1110.
- **Mid-frame reset:** assert rst for 1 cycle while idx=2.
	- The next edge shows all reset values and idx=0.
	- The display stays dark until the next frame_start, 32 cycles later.
